// File: rtl/ftdi_fifo_bridge_if.sv
// Stream-side and FTDI strobe signals of the FT245-style FIFO bridge.
// slave: the bridge itself; master: the surrounding logic / pad model.
interface ftdi_fifo_bridge_if #(
   parameter int unsigned TX_DEPTH = 16,
   parameter int unsigned RX_DEPTH = 16
) ();
   // FTDI status and strobes
   logic                        in_ftdi_txe;
   logic                        in_ftdi_rxf;
   logic                        out_ftdi_wr;
   logic                        out_ftdi_rd;
   // Streaming side
   logic                        in_rx_en;
   logic                        in_tx_valid;
   logic                        out_tx_ready;
   logic [7:0]                  in_tx_data;
   logic                        out_rx_valid;
   logic                        in_rx_ready;
   logic [7:0]                  out_rx_data;
   logic [$clog2(TX_DEPTH):0]   out_tx_level;
   logic [$clog2(RX_DEPTH):0]   out_rx_level;

   modport slave (
      input  in_ftdi_txe, in_ftdi_rxf, in_rx_en, in_tx_valid, in_tx_data, in_rx_ready,
      output out_ftdi_wr, out_ftdi_rd, out_tx_ready, out_rx_valid, out_rx_data,
             out_tx_level, out_rx_level
   );

   modport master (
      output in_ftdi_txe, in_ftdi_rxf, in_rx_en, in_tx_valid, in_tx_data, in_rx_ready,
      input  out_ftdi_wr, out_ftdi_rd, out_tx_ready, out_rx_valid, out_rx_data,
             out_tx_level, out_rx_level
   );
endinterface

// File: rtl/ftdi_fifo_bridge.sv
// FT245-style parallel FIFO bridge: TX/RX byte FIFOs with valid/ready ports,
// parametrised RD/WR strobe timing, bus turnaround and token-based RX/TX
// arbitration. Strobes and bus enable decode from the registered state only.
module ftdi_fifo_bridge #(
   parameter int unsigned TX_DEPTH    = 16,
   parameter int unsigned RX_DEPTH    = 16,
   parameter int unsigned T_RD_ACTIVE = 4,
   parameter int unsigned T_RD_SAMPLE = 3,
   parameter int unsigned T_WR_SETUP  = 2,
   parameter int unsigned T_WR_ACTIVE = 4,
   parameter int unsigned T_TURN      = 1,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                 in_clk,
   input  logic                 in_rst_n,
   inout  wire  [7:0]           io_ftdi_data,
   ftdi_fifo_bridge_if.slave    bus_if
);

   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam int unsigned RX_AW = $clog2(RX_DEPTH);

   localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(T_RD_ACTIVE - 1);
   localparam logic [CNT_W-1:0] RD_SAMPLE  = CNT_W'(T_RD_SAMPLE);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_WR_SETUP - 1);
   localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(T_WR_ACTIVE - 1);
   localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(T_TURN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR_SETUP,
      S_WR,
      S_TURN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tok_rx_q, tok_rx_d;   // 1: RX wins a tie, 0: TX wins
   logic [7:0]       rd_byte_q, rd_byte_d;

   // ---------------- TX FIFO ----------------
   logic [7:0]       tx_mem_q [TX_DEPTH];
   logic [TX_AW-1:0] tx_wp_q, tx_rp_q;
   logic [TX_AW:0]   tx_lvl_q;
   logic             tx_full, tx_empty, tx_push, tx_pop;
   logic [7:0]       tx_head;

   // ---------------- RX FIFO ----------------
   logic [7:0]       rx_mem_q [RX_DEPTH];
   logic [RX_AW-1:0] rx_wp_q, rx_rp_q;
   logic [RX_AW:0]   rx_lvl_q;
   logic             rx_full, rx_empty, rx_push, rx_pop;
   logic [7:0]       rx_push_data;

   logic             rd_ok, wr_ok, bus_oe;

   assign tx_full  = (tx_lvl_q == (TX_AW+1)'(TX_DEPTH));
   assign tx_empty = (tx_lvl_q == '0);
   assign tx_push  = bus_if.in_tx_valid && !tx_full;
   assign tx_head  = tx_mem_q[tx_rp_q];

   assign rx_full  = (rx_lvl_q == (RX_AW+1)'(RX_DEPTH));
   assign rx_empty = (rx_lvl_q == '0);
   assign rx_pop   = !rx_empty && bus_if.in_rx_ready;

   assign bus_if.out_tx_ready = !tx_full;
   assign bus_if.out_tx_level = tx_lvl_q;
   assign bus_if.out_rx_valid = !rx_empty;
   // Memory is not reset, so mask the head while empty to present zero.
   assign bus_if.out_rx_data  = rx_empty ? '0 : rx_mem_q[rx_rp_q];
   assign bus_if.out_rx_level = rx_lvl_q;

   // Pad-side decode from registered state
   assign bus_if.out_ftdi_rd = (state_q == S_RD);
   assign bus_if.out_ftdi_wr = (state_q == S_WR);
   assign bus_oe             = (state_q == S_WR_SETUP) || (state_q == S_WR);
   assign io_ftdi_data       = bus_oe ? tx_head : 8'bz;

   // TX storage write port
   always_ff @(posedge in_clk) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= bus_if.in_tx_data;
   end

   // TX pointers and occupancy
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_lvl_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_lvl_q <= tx_lvl_q + 1'b1;
            2'b01:   tx_lvl_q <= tx_lvl_q - 1'b1;
            default: tx_lvl_q <= tx_lvl_q;
         endcase
      end
   end

   // RX storage write port
   always_ff @(posedge in_clk) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= rx_push_data;
   end

   // RX pointers and occupancy
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_lvl_q <= '0;
      end else begin
         if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_lvl_q <= rx_lvl_q + 1'b1;
            2'b01:   rx_lvl_q <= rx_lvl_q - 1'b1;
            default: rx_lvl_q <= rx_lvl_q;
         endcase
      end
   end

   // FSM state, delay counter, arbitration token and captured read byte
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tok_rx_q  <= 1'b1;
         rd_byte_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tok_rx_q  <= tok_rx_d;
         rd_byte_q <= rd_byte_d;
      end
   end

   assign rd_ok = bus_if.in_rx_en && bus_if.in_ftdi_rxf && !rx_full;
   assign wr_ok = bus_if.in_ftdi_txe && !tx_empty;

   // Next-state, counter, FIFO push/pop strobes
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tok_rx_d     = tok_rx_q;
      rd_byte_d    = rd_byte_q;
      tx_pop       = 1'b0;
      rx_push      = 1'b0;
      rx_push_data = rd_byte_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rd_ok && (!wr_ok || tok_rx_q)) state_d = S_RD;
            else if (wr_ok)                    state_d = S_WR_SETUP;
         end
         S_RD: begin
            if (cnt_q == RD_SAMPLE) rd_byte_d = io_ftdi_data;
            if (cnt_q == RD_LAST) begin
               // Sample point may coincide with the last RD cycle; push the live bus then.
               rx_push      = 1'b1;
               rx_push_data = (cnt_q == RD_SAMPLE) ? io_ftdi_data : rd_byte_q;
               tok_rx_d     = 1'b0;
               cnt_d        = '0;
               state_d      = S_TURN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WR_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = S_WR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WR: begin
            if (cnt_q == WR_LAST) begin
               tx_pop   = 1'b1;
               tok_rx_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_TURN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_TURN: begin
            if (cnt_q == TURN_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
